// File: rtl/dsdaccel_pkg.sv
// rtl/dsdaccel_pkg.sv - shared constants, state encoding and helpers for the inference ROM sequencer
package dsdaccel_pkg;

   localparam logic [9:0] ADDR_L1W_BASE = 10'd0;
   localparam logic [9:0] ADDR_L2W_BASE = 10'd768;
   localparam logic [9:0] ADDR_L3W_BASE = 10'd896;
   localparam logic [9:0] ADDR_L1OUT    = 10'd920;
   localparam logic [9:0] ADDR_L2OUT    = 10'd921;
   localparam logic [9:0] ADDR_IMG_BASE = 10'd960;
   localparam logic [1:0] L1_CHUNKS     = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE, S_L1, S_W1, S_WB1, S_L2, S_W2, S_WB2, S_L3, S_W3, S_FIN
   } romseq_state_t;

   // Layer number tagged onto reads issued from an Lx state
   function automatic logic [1:0] layer_of(romseq_state_t s);
      case (s)
         S_L1:    return 2'd1;
         S_L2:    return 2'd2;
         S_L3:    return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/dsdaccel_romseq_if.sv
// rtl/dsdaccel_romseq_if.sv - control and RAM/MAC-side signal bundle of the ROM sequencer
interface dsdaccel_romseq_if;
   logic       i_START;
   logic       i_MAC_READY;
   logic       o_BUSY;
   logic       o_DONE;
   logic [9:0] o_PA_ADDR;
   logic [9:0] o_PB_ADDR;
   logic       o_PB_WE;
   logic       o_RD_VALID;
   logic [1:0] o_LAYER;
   logic [7:0] o_NEURON;
   logic [1:0] o_CHUNK;
   logic       o_NEURON_LAST;

   modport master (
      input  i_START, i_MAC_READY,
      output o_BUSY, o_DONE, o_PA_ADDR, o_PB_ADDR, o_PB_WE,
             o_RD_VALID, o_LAYER, o_NEURON, o_CHUNK, o_NEURON_LAST
   );

   modport slave (
      output i_START, i_MAC_READY,
      input  o_BUSY, o_DONE, o_PA_ADDR, o_PB_ADDR, o_PB_WE,
             o_RD_VALID, o_LAYER, o_NEURON, o_CHUNK, o_NEURON_LAST
   );
endinterface

// File: rtl/dsdaccel_romseq.sv
// rtl/dsdaccel_romseq.sv - issues all layer reads and writebacks of one inference
module dsdaccel_romseq
   import dsdaccel_pkg::*;
#(
   parameter int L1_NEURONS = 256,
   parameter int L2_NEURONS = 128,
   parameter int L3_NEURONS = 10,
   parameter int MAC_LAT    = 2
) (
   input  logic          i_CLK,
   input  logic          i_RST,
   dsdaccel_romseq_if.master bus
);

   localparam int WAIT_W = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;
   localparam logic [7:0] L1_LAST = 8'(L1_NEURONS - 1);
   localparam logic [7:0] L2_LAST = 8'(L2_NEURONS - 1);
   localparam logic [7:0] L3_LAST = 8'(L3_NEURONS - 1);

   romseq_state_t     state_q, state_d;
   logic [7:0]        neuron_q, neuron_d;
   logic [1:0]        chunk_q, chunk_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [9:0]        pa_q, pa_d, pb_q, pb_d;
   logic              we_q, we_d, busy_q, busy_d, done_q, done_d;
   logic              valid_q, valid_d, tlast_q, tlast_d;
   logic [1:0]        layer_q, layer_d, tchunk_q, tchunk_d;
   logic [7:0]        tneuron_q, tneuron_d;
   logic              chunk_end, neuron_end;

   // State, counters and every output register; reset drops everything including in-flight valid
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q   <= S_IDLE;
         neuron_q  <= '0;
         chunk_q   <= '0;
         wait_q    <= '0;
         pa_q      <= '0;
         pb_q      <= '0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         layer_q   <= '0;
         tneuron_q <= '0;
         tchunk_q  <= '0;
         tlast_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         neuron_q  <= neuron_d;
         chunk_q   <= chunk_d;
         wait_q    <= wait_d;
         pa_q      <= pa_d;
         pb_q      <= pb_d;
         we_q      <= we_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
         layer_q   <= layer_d;
         tneuron_q <= tneuron_d;
         tchunk_q  <= tchunk_d;
         tlast_q   <= tlast_d;
      end
   end

   // Next state, issue counters, next addresses and the tags of the read issued this cycle
   always_comb begin
      state_d    = state_q;
      neuron_d   = neuron_q;
      chunk_d    = chunk_q;
      wait_d     = wait_q;
      pa_d       = pa_q;
      pb_d       = pb_q;
      valid_d    = 1'b0;
      layer_d    = 2'd0;
      tneuron_d  = 8'd0;
      tchunk_d   = 2'd0;
      tlast_d    = 1'b0;
      chunk_end  = 1'b1;
      neuron_end = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_START) begin
               state_d  = S_L1;
               pa_d     = ADDR_L1W_BASE;
               pb_d     = ADDR_IMG_BASE;
               neuron_d = '0;
               chunk_d  = '0;
            end
         end
         S_L1, S_L2, S_L3: begin
            if (bus.i_MAC_READY) begin
               chunk_end = (state_q != S_L1) || (chunk_q == L1_CHUNKS - 2'd1);
               case (state_q)
                  S_L1:    neuron_end = (neuron_q == L1_LAST);
                  S_L2:    neuron_end = (neuron_q == L2_LAST);
                  default: neuron_end = (neuron_q == L3_LAST);
               endcase
               valid_d   = 1'b1;
               layer_d   = layer_of(state_q);
               tneuron_d = neuron_q;
               tchunk_d  = chunk_q;
               tlast_d   = chunk_end;
               if (chunk_end && neuron_end) begin
                  // Last read of the layer: addresses hold through the drain wait
                  neuron_d = '0;
                  chunk_d  = '0;
                  wait_d   = WAIT_W'(MAC_LAT);
                  case (state_q)
                     S_L1:    state_d = S_W1;
                     S_L2:    state_d = S_W2;
                     default: state_d = S_W3;
                  endcase
               end else begin
                  // Weight rows are contiguous in every layer (3n+c is sequential in L1)
                  pa_d = pa_q + 10'd1;
                  if (chunk_end) begin
                     neuron_d = neuron_q + 8'd1;
                     chunk_d  = '0;
                  end else begin
                     chunk_d = chunk_q + 2'd1;
                  end
                  if (state_q == S_L1) pb_d = ADDR_IMG_BASE + {8'd0, chunk_d};
               end
            end
         end
         S_W1, S_W2, S_W3: begin
            if (wait_q == '0) begin
               case (state_q)
                  S_W1: begin state_d = S_WB1; pb_d = ADDR_L1OUT; end
                  S_W2: begin state_d = S_WB2; pb_d = ADDR_L2OUT; end
                  default: state_d = S_FIN;
               endcase
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         S_WB1: begin
            state_d = S_L2;
            pa_d    = ADDR_L2W_BASE;
            pb_d    = ADDR_L1OUT;
         end
         S_WB2: begin
            state_d = S_L3;
            pa_d    = ADDR_L3W_BASE;
            pb_d    = ADDR_L2OUT;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = !(state_d inside {S_IDLE, S_FIN});
      done_d = (state_d == S_FIN);
      we_d   = (state_d inside {S_WB1, S_WB2});
   end

   assign bus.o_BUSY        = busy_q;
   assign bus.o_DONE        = done_q;
   assign bus.o_PA_ADDR     = pa_q;
   assign bus.o_PB_ADDR     = pb_q;
   assign bus.o_PB_WE       = we_q;
   assign bus.o_RD_VALID    = valid_q;
   assign bus.o_LAYER       = layer_q;
   assign bus.o_NEURON      = tneuron_q;
   assign bus.o_CHUNK       = tchunk_q;
   assign bus.o_NEURON_LAST = tlast_q;

endmodule

// File: tb/tb_dsdaccel_romseq.sv
// tb/tb_dsdaccel_romseq.sv - self-checking bench for dsdaccel_romseq (MAC_LAT=2 and MAC_LAT=0 builds)
module tb_dsdaccel_romseq;

   localparam int N = 2048;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_r = 1'b0;
   logic ready_r = 1'b1;

   always #5 clk = ~clk;

   dsdaccel_romseq_if bus0();
   dsdaccel_romseq_if bus1();

   assign bus0.i_START = start_r;
   assign bus0.i_MAC_READY = ready_r;
   assign bus1.i_START = start_r;
   assign bus1.i_MAC_READY = ready_r;

   dsdaccel_romseq #(.MAC_LAT(2)) u_dut0 (.i_CLK(clk), .i_RST(rst), .bus(bus0));
   dsdaccel_romseq #(.MAC_LAT(0)) u_dut1 (.i_CLK(clk), .i_RST(rst), .bus(bus1));

   // Packed view: {busy, done, valid, we, pa, pb, layer, neuron, chunk, last}
   logic [36:0] act [2];
   assign act[0] = {bus0.o_BUSY, bus0.o_DONE, bus0.o_RD_VALID, bus0.o_PB_WE, bus0.o_PA_ADDR,
                    bus0.o_PB_ADDR, bus0.o_LAYER, bus0.o_NEURON, bus0.o_CHUNK, bus0.o_NEURON_LAST};
   assign act[1] = {bus1.o_BUSY, bus1.o_DONE, bus1.o_RD_VALID, bus1.o_PB_WE, bus1.o_PA_ADDR,
                    bus1.o_PB_ADDR, bus1.o_LAYER, bus1.o_NEURON, bus1.o_CHUNK, bus1.o_NEURON_LAST};

   int n_cmp = 0;
   int n_bad = 0;

   bit rdy_a [N];
   bit st_a  [N];
   bit rs_a  [N];

   bit         e_busy [2][N];
   bit         e_done [2][N];
   bit         e_valid[2][N];
   bit         e_we   [2][N];
   bit         e_ca   [2][N];
   bit         e_ct   [2][N];
   logic [9:0] e_pa   [2][N];
   logic [9:0] e_pb   [2][N];
   logic [1:0] e_layer[2][N];
   logic [7:0] e_neur [2][N];
   logic [1:0] e_chunk[2][N];
   bit         e_last [2][N];
   int         m_done [2];

   int obs_done_first[2];
   int obs_done_cnt  [2];
   int obs_we_first  [2];
   int obs_v         [2][4];

   task automatic clear_inputs();
      for (int c = 0; c < N; c++) begin
         rdy_a[c] = 1'b1;
         st_a[c]  = 1'b0;
         rs_a[c]  = 1'b0;
      end
   endtask

   task automatic clear_model(input int d, input int from);
      for (int t = from; t < N; t++) begin
         e_busy[d][t] = 0; e_done[d][t] = 0; e_valid[d][t] = 0; e_we[d][t] = 0;
         e_ca[d][t] = 0; e_ct[d][t] = 0; e_pa[d][t] = '0; e_pb[d][t] = '0;
         e_layer[d][t] = '0; e_neur[d][t] = '0; e_chunk[d][t] = '0; e_last[d][t] = 0;
      end
   endtask

   task automatic set_addr(input int d, input int t, input logic [9:0] pa, input logic [9:0] pb);
      e_busy[d][t] = 1;
      e_ca[d][t]   = 1;
      e_pa[d][t]   = pa;
      e_pb[d][t]   = pb;
   endtask

   // Timeline model: walk the layer read lists, spending one cycle per read plus one per stalled cycle
   task automatic build_model(input int d, input int lat, input int off);
      int t, nn, nc;
      logic [9:0] pa, pb;
      t = off + 1;
      pa = '0;
      pb = '0;
      for (int l = 1; l <= 3; l++) begin
         nn = (l == 1) ? 256 : (l == 2) ? 128 : 10;
         nc = (l == 1) ? 3 : 1;
         for (int n = 0; n < nn; n++) begin
            for (int c = 0; c < nc; c++) begin
               pa = (l == 1) ? 10'(3 * n + c) : (l == 2) ? 10'(768 + n) : 10'(896 + n);
               pb = (l == 1) ? 10'(960 + c) : (l == 2) ? 10'd920 : 10'd921;
               while (t < N - 4) begin
                  set_addr(d, t, pa, pb);
                  if (rdy_a[t]) break;
                  t++;
               end
               e_valid[d][t+1] = 1;
               e_ct[d][t+1]    = 1;
               e_layer[d][t+1] = 2'(l);
               e_neur[d][t+1]  = 8'(n);
               e_chunk[d][t+1] = 2'(c);
               e_last[d][t+1]  = (c == nc - 1);
               t++;
            end
         end
         for (int w = 0; w <= lat; w++) begin
            set_addr(d, t, pa, pb);
            t++;
         end
         if (l < 3) begin
            set_addr(d, t, pa, (l == 1) ? 10'd920 : 10'd921);
            e_we[d][t] = 1;
            t++;
         end
      end
      e_done[d][t] = 1;
      m_done[d] = t;
   endtask

   task automatic build_all(input int rst_at, input int restart_at);
      for (int d = 0; d < 2; d++) begin
         clear_model(d, 0);
         build_model(d, (d == 0) ? 2 : 0, 0);
         if (rst_at >= 0) begin
            clear_model(d, rst_at + 1);
            for (int t = rst_at + 1; t <= restart_at; t++) begin
               e_ca[d][t] = 1;
               e_ct[d][t] = 1;
            end
            build_model(d, (d == 0) ? 2 : 0, restart_at);
         end
      end
   endtask

   // Drives the input tables cycle by cycle and compares both DUTs against the model each cycle
   task automatic run_scenario(input string name, input int count_from);
      int last_c;
      logic [36:0] a, e;
      last_c = ((m_done[0] > m_done[1]) ? m_done[0] : m_done[1]) + 3;
      for (int d = 0; d < 2; d++) begin
         obs_done_first[d] = -1; obs_done_cnt[d] = 0; obs_we_first[d] = -1;
         for (int l = 0; l < 4; l++) obs_v[d][l] = 0;
      end
      @(negedge clk); rst = 1'b1; start_r = 1'b0; ready_r = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      for (int c = 0; c <= last_c; c++) begin
         if (c > 0) @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            a = act[d];
            e = {e_busy[d][c], e_done[d][c], e_valid[d][c], e_we[d][c], e_pa[d][c], e_pb[d][c],
                 e_layer[d][c], e_neur[d][c], e_chunk[d][c], e_last[d][c]};
            if (!e_ca[d][c]) begin a[32:13] = '0; e[32:13] = '0; end
            if (!e_ct[d][c]) begin a[12:0] = '0; e[12:0] = '0; end
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL %s dut%0d cycle %0d: got %h want %h", name, d, c, a, e);
            end
            if (act[d][35]) begin
               obs_done_cnt[d]++;
               if (obs_done_first[d] < 0) obs_done_first[d] = c;
            end
            if (act[d][33] && obs_we_first[d] < 0 && c > count_from) obs_we_first[d] = c;
            if (act[d][34] && c > count_from) obs_v[d][act[d][12:11]]++;
         end
         start_r = st_a[c];
         ready_r = rdy_a[c];
         rst     = rs_a[c];
      end
      start_r = 1'b0;
      ready_r = 1'b1;
      rst     = 1'b0;
   endtask

   task automatic check_int(input string name, input int got, input int want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      @(negedge clk); rst = 1'b1; start_r = 1'b1; ready_r = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (act[d] !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_state dut%0d: got %h want 0", d, act[d]);
         end
      end
      rst = 1'b0; start_r = 1'b0;
   endtask

   task automatic test_full_run();
      clear_inputs();
      st_a[0] = 1'b1;
      build_all(-1, 0);
      run_scenario("full_run", 0);
      check_int("full_done_lat2", obs_done_first[0], 918);
      check_int("full_done_lat0", obs_done_first[1], 912);
      check_int("full_wb1_lat2", obs_we_first[0], 772);
      check_int("full_wb1_lat0", obs_we_first[1], 770);
      for (int d = 0; d < 2; d++) begin
         check_int("full_done_count", obs_done_cnt[d], 1);
         check_int("full_l1_reads", obs_v[d][1], 768);
         check_int("full_l2_reads", obs_v[d][2], 128);
         check_int("full_l3_reads", obs_v[d][3], 10);
      end
   endtask

   task automatic test_stall();
      clear_inputs();
      st_a[0] = 1'b1;
      for (int c = 400; c <= 404; c++) rdy_a[c] = 1'b0;
      build_all(-1, 0);
      run_scenario("stall", 0);
      check_int("stall_done_lat2", obs_done_first[0], 923);
      check_int("stall_done_lat0", obs_done_first[1], 917);
   endtask

   task automatic test_start_ignored();
      clear_inputs();
      st_a[0] = 1'b1;
      st_a[500] = 1'b1;
      build_all(-1, 0);
      run_scenario("start_busy", 0);
      check_int("start_busy_done", obs_done_first[0], 918);
      check_int("start_busy_count", obs_done_cnt[0], 1);
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      st_a[0] = 1'b1;
      rs_a[800] = 1'b1;
      st_a[810] = 1'b1;
      build_all(800, 810);
      run_scenario("reset_mid", 810);
      check_int("reset_mid_done_lat2", obs_done_first[0], 1728);
      check_int("reset_mid_done_lat0", obs_done_first[1], 1722);
      check_int("reset_mid_l1_reads", obs_v[0][1], 768);
   endtask

   task automatic test_random_stall();
      int stalls;
      clear_inputs();
      st_a[0] = 1'b1;
      stalls = 0;
      for (int c = 1; c <= 600; c++) begin
         rdy_a[c] = ($urandom_range(0, 3) != 0);
         if (!rdy_a[c]) stalls++;
      end
      build_all(-1, 0);
      run_scenario("random_stall", 0);
      check_int("random_l1_reads", obs_v[0][1], 768);
      check_int("random_l2_reads", obs_v[0][2], 128);
      check_int("random_l3_reads", obs_v[0][3], 10);
      check_int("random_done_lat2", obs_done_first[0], 918 + stalls);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      test_reset();
      test_full_run();
      test_stall();
      test_start_ignored();
      test_reset_mid();
      test_random_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dsdaccel_romseq.md
Name: dsdaccel_romseq

Overview:
- Inference sequencer for the dual-port 1024 x (262*8) weight/activation RAM.
- On start, issues every layer-1/2/3 read: port A carries weight rows, port B carries activation rows; both are delivered to the MAC datapath with a valid strobe.
- After layers 1 and 2, issues the single port-B writeback of the layer output vector, then signals done.
- Sits between the top-level control FSM and the RAM/MAC datapath.

Parameters:
- L1_NEURONS, 256, layer-1 neuron count (3 chunk reads each)
- L2_NEURONS, 128, layer-2 neuron count (1 read each)
- L3_NEURONS, 10, layer-3 neuron count (1 read each)
- MAC_LAT, 2, datapath cycles from last valid data until the layer output vector is stable at port-B DIN

Ports:
- i_CLK  in  1  clock, all logic on rising edge
- i_RST  in  1  synchronous active-high reset
- i_START  in  1  start inference; sampled only in IDLE
- i_MAC_READY  in  1  datapath can accept a new read this cycle; low = stall issue
- o_BUSY  out  1  high from first issue until the cycle before o_DONE
- o_DONE  out  1  one-cycle pulse at end of inference
- o_PA_ADDR  out  10  RAM port A address (weight row)
- o_PB_ADDR  out  10  RAM port B address (activation row / writeback row)
- o_PB_WE  out  1  RAM port B write enable (writeback cycle only)
- o_RD_VALID  out  1  RAM DOUT on both ports valid this cycle (1 cycle after issue)
- o_LAYER  out  2  layer of the data at DOUT (1..3, 0 when idle)
- o_NEURON  out  8  neuron index of the data at DOUT
- o_CHUNK  out  2  chunk index of the data at DOUT (layer 1: 0..2, else 0)
- o_NEURON_LAST  out  1  with o_RD_VALID: final read of this neuron; accumulator may close

Behaviour:
- All outputs are registered. Reset (any state, including mid-layer) forces IDLE, all outputs 0, all counters 0; in-flight valid is dropped.
- States: IDLE, L1, W1, WB1, L2, W2, WB2, L3, W3, FIN.
- IDLE: i_START=1 -> L1, first issue visible the next cycle. i_START outside IDLE is ignored.
- Issue address map:
  - L1, neuron n, chunk c: PA = 3n+c, PB = 960+c; c counts 0..2, then n increments.
  - L2: PA = 768+n, PB = 920.
  - L3: PA = 896+n, PB = 921.
- An issue occurs in a cycle where state is Lx and i_MAC_READY=1.
  - On issue, the counters advance and the next addresses are registered.
  - If i_MAC_READY=0, addresses and counters hold and no issue is counted.
- o_RD_VALID, o_LAYER, o_NEURON, o_CHUNK and o_NEURON_LAST form a 1-cycle delayed copy of the issue tags, aligned with RAM DOUT.
  - A read issued before a stall still reports valid in the next cycle; the datapath must absorb it.
- Last issue of a layer (n = Lx_NEURONS-1 and, for L1, c = 2) -> Wx.
- Wx waits exactly 1+MAC_LAT cycles (down-counter) and ignores i_MAC_READY.
  - W1 -> WB1, W2 -> WB2, W3 -> FIN.
- WBx is one cycle: o_PB_WE=1, o_PB_ADDR = 920 (WB1) or 921 (WB2), o_PA_ADDR held. Next state is L2 or L3; first issue is the next cycle.
- FIN: o_DONE=1 and o_BUSY=0 for one cycle -> IDLE. Layer-3 results are not written back.
- o_PB_WE is never high in Lx/Wx states; no read is issued during WBx.
- Counter widths: neuron 8 bits, chunk 2 bits, wait counter sized for MAC_LAT+1. No wrap beyond the limits.
- Unstalled timing, START sampled at cycle 0, MAC_LAT=2:
  - L1 issues cycles 1..768, W1 769..771, WB1 772
  - L2 issues 773..900, W2 901..903, WB2 904
  - L3 issues 905..914, W3 915..917
  - o_DONE at cycle 918
- Each stalled issue cycle delays o_DONE by exactly 1.

Decomposition:
- Package dsdaccel_pkg:
  - address constants ADDR_L1W_BASE=0, ADDR_L2W_BASE=768, ADDR_L3W_BASE=896, ADDR_L1OUT=920, ADDR_L2OUT=921, ADDR_IMG_BASE=960
  - L1_CHUNKS=3
  - state enum romseq_state_t
- Single flat module; the issue counter and address generation stay inline. No sub-module is warranted.

Test Plan:
- Reset, then START at cycle 0, i_MAC_READY=1:
  - cycle 1 PA=0/PB=960; cycle 2 PA=1/PB=961; cycle 3 PA=2/PB=962
  - cycle 4 o_RD_VALID=1, o_NEURON=0, o_CHUNK=2, o_NEURON_LAST=1
  - WB1 at 772 (PB_WE=1, PB=920), WB2 at 904 (PB=921), o_DONE at 918 only
- Full run, scoreboard: exactly 768/128/10 valid reads for layers 1/2/3.
  - last L1 read PA=767; first L2 PA=768/PB=920; last L3 PA=905/PB=921
- i_MAC_READY low for 5 cycles at cycle 400 -> addresses frozen during the stall, no valid after the one in-flight beat, o_DONE at 923.
- START pulsed at cycle 500 while busy -> ignored: single o_DONE at 918, no restart.
- i_RST at cycle 800 (inside L2) -> next cycle all outputs 0, state IDLE; START at 810 -> PA=0 at 811, o_DONE at 1728.
- MAC_LAT=0 build -> W1 lasts 1 cycle, WB1 at 770, o_DONE at 912.
